// File: rtl/pe_seq_pkg.sv
// Shared types and precision encodings for the PE dot-product sequencer.
package pe_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StStream,
    StDrain,
    StCapture,
    StDone
  } seq_state_e;

  localparam logic [2:0] PREC_1B      = 3'b000;
  localparam logic [2:0] PREC_2B      = 3'b001;
  localparam logic [2:0] PREC_4B      = 3'b010;
  localparam logic [2:0] PREC_8B      = 3'b011;
  localparam logic [2:0] PREC_DEFAULT = PREC_1B;

  // Encodings 1xx are not supported by the PE and fall back to the default.
  function automatic logic [2:0] coerce_prec(input logic [2:0] prec);
    return prec[2] ? PREC_DEFAULT : prec;
  endfunction

endpackage

// File: rtl/pe_seq_stats.sv
// Free-running beat and zero-skip counters; only built when PE_SEQ_STATS_EN is defined.
module pe_seq_stats (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        beat,
  input  logic        skip,
  output logic [31:0] stat_beats,
  output logic [31:0] stat_skipped
);

  logic [31:0] beats_q, skipped_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      beats_q   <= '0;
      skipped_q <= '0;
    end else begin
      if (beat) beats_q <= beats_q + 32'd1;
      if (skip) skipped_q <= skipped_q + 32'd1;
    end
  end

  assign stat_beats   = beats_q;
  assign stat_skipped = skipped_q;

endmodule

// File: rtl/pe_dot_sequencer.sv
// Job controller driving one adaptive_pe through a full dot product.
// Optional statistics counters are enabled by defining PE_SEQ_STATS_EN.
module pe_dot_sequencer
  import pe_seq_pkg::*;
#(
  parameter int unsigned MAX_WIDTH     = 64,
  parameter int unsigned MAX_ACC_WIDTH = 20,
  parameter int unsigned LEN_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_precision,
  input  logic [LEN_WIDTH-1:0]     cmd_len,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [MAX_WIDTH-1:0]     op_weight,
  input  logic [MAX_WIDTH-1:0]     op_activation,
  input  logic [MAX_WIDTH-1:0]     op_mask,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [MAX_ACC_WIDTH-1:0] res_sum,
  output logic                     res_prec_err,
  output logic                     pe_ce,
  output logic                     pe_accumulate,
  output logic [2:0]               pe_precision_mode,
  output logic [MAX_WIDTH-1:0]     pe_weight,
  output logic [MAX_WIDTH-1:0]     pe_activation,
  output logic [MAX_WIDTH-1:0]     pe_mask,
  input  logic [MAX_ACC_WIDTH-1:0] pe_sum,
  input  logic                     pe_skipped,
  output logic                     busy,
  output logic [31:0]              stat_beats,
  output logic [31:0]              stat_skipped
);

  seq_state_e               state_q;
  logic [LEN_WIDTH-1:0]     remaining_q;
  logic                     cmd_ready_q, prec_err_q;
  logic [2:0]               precision_q;
  logic                     pe_ce_q, pe_accumulate_q;
  logic [MAX_WIDTH-1:0]     pe_weight_q, pe_activation_q, pe_mask_q;
  logic [MAX_ACC_WIDTH-1:0] res_sum_q;
  logic                     res_prec_err_q;
  logic                     cmd_fire, beat, skip_event;

  assign cmd_fire   = cmd_valid && cmd_ready_q && (state_q == StIdle);
  assign op_ready   = (state_q == StStream) && (remaining_q != '0);
  assign beat       = op_valid && op_ready;
  // Accumulating edges only, so the CLEAR edge is never counted as a skip.
  assign skip_event = pe_ce_q && pe_accumulate_q && pe_skipped;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      remaining_q     <= '0;
      cmd_ready_q     <= 1'b0;
      prec_err_q      <= 1'b0;
      precision_q     <= PREC_DEFAULT;
      pe_ce_q         <= 1'b0;
      pe_accumulate_q <= 1'b0;
      pe_weight_q     <= '0;
      pe_activation_q <= '0;
      pe_mask_q       <= '0;
      res_sum_q       <= '0;
      res_prec_err_q  <= 1'b0;
    end else begin
      pe_ce_q         <= cmd_fire || beat;
      pe_accumulate_q <= beat;
      unique case (state_q)
        StIdle: begin
          cmd_ready_q <= !cmd_fire;
          if (cmd_fire) begin
            precision_q     <= coerce_prec(cmd_precision);
            prec_err_q      <= cmd_precision[2];
            remaining_q     <= cmd_len;
            // All-ones operands keep the PE zero-skip from masking the clear.
            pe_weight_q     <= '1;
            pe_activation_q <= '1;
            pe_mask_q       <= '1;
            state_q         <= StClear;
          end
        end
        StClear: state_q <= (remaining_q == '0) ? StCapture : StStream;
        StStream: begin
          if (beat) begin
            pe_weight_q     <= op_weight;
            pe_activation_q <= op_activation;
            pe_mask_q       <= op_mask;
            remaining_q     <= remaining_q - LEN_WIDTH'(1);
            if (remaining_q == LEN_WIDTH'(1)) state_q <= StDrain;
          end
        end
        StDrain: state_q <= StCapture;
        StCapture: begin
          res_sum_q      <= pe_sum;
          res_prec_err_q <= prec_err_q;
          state_q        <= StDone;
        end
        StDone: begin
          if (res_ready) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready         = cmd_ready_q;
  assign res_valid         = (state_q == StDone);
  assign busy              = (state_q != StIdle);
  assign res_sum           = res_sum_q;
  assign res_prec_err      = res_prec_err_q;
  assign pe_ce             = pe_ce_q;
  assign pe_accumulate     = pe_accumulate_q;
  assign pe_precision_mode = precision_q;
  assign pe_weight         = pe_weight_q;
  assign pe_activation     = pe_activation_q;
  assign pe_mask           = pe_mask_q;

`ifdef PE_SEQ_STATS_EN
  pe_seq_stats u_stats (
    .clk          (clk),
    .reset_n      (reset_n),
    .beat         (beat),
    .skip         (skip_event),
    .stat_beats   (stat_beats),
    .stat_skipped (stat_skipped)
  );
`else
  logic unused_skip;
  assign unused_skip  = skip_event;
  assign stat_beats   = '0;
  assign stat_skipped = '0;
`endif

endmodule

// File: tb/tb_pe_dot_sequencer.sv
// Directed bench for pe_dot_sequencer with a behavioural adaptive_pe model.
module tb_pe_dot_sequencer;

  localparam int unsigned MW = 64;
  localparam int unsigned AW = 20;
  localparam int unsigned LW = 16;
  localparam logic [MW-1:0] ONES = '1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [2:0]    cmd_precision = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          op_valid = 1'b0, op_ready;
  logic [MW-1:0] op_weight = '0, op_activation = '0, op_mask = '0;
  logic          res_valid, res_ready = 1'b0;
  logic [AW-1:0] res_sum;
  logic          res_prec_err;
  logic          pe_ce, pe_accumulate;
  logic [2:0]    pe_precision_mode;
  logic [MW-1:0] pe_weight, pe_activation, pe_mask;
  logic [AW-1:0] pe_sum;
  logic          pe_skipped;
  logic          busy;
  logic [31:0]   stat_beats, stat_skipped;

  int n_cmp = 0;
  int n_fail = 0;
  logic [MW-1:0] bw[8], ba[8], bm[8];

  always #5 clk = ~clk;

  pe_dot_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_precision(cmd_precision), .cmd_len(cmd_len),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_weight(op_weight), .op_activation(op_activation), .op_mask(op_mask),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_prec_err(res_prec_err),
    .pe_ce(pe_ce), .pe_accumulate(pe_accumulate),
    .pe_precision_mode(pe_precision_mode),
    .pe_weight(pe_weight), .pe_activation(pe_activation), .pe_mask(pe_mask),
    .pe_sum(pe_sum), .pe_skipped(pe_skipped),
    .busy(busy), .stat_beats(stat_beats), .stat_skipped(stat_skipped)
  );

  // Behavioural PE: per-element unsigned products of (weight & mask) and activation.
  function automatic logic [AW-1:0] pe_dot(input logic [MW-1:0] w, input logic [MW-1:0] a,
                                           input logic [MW-1:0] m, input logic [2:0] p);
    int ew;
    logic [MW-1:0] wm;
    longint unsigned emask, acc;
    ew = 1 << p[1:0];
    wm = w & m;
    emask = (64'd1 << ew) - 64'd1;
    acc = 0;
    for (int i = 0; i < int'(MW); i += ew)
      acc += ((wm >> i) & emask) * ((a >> i) & emask);
    return acc[AW-1:0];
  endfunction

  logic [AW-1:0] pe_acc;
  logic skip_cond;
  assign skip_cond  = ((pe_weight & pe_mask) == '0) || (pe_activation == '0);
  assign pe_skipped = pe_ce && skip_cond;
  assign pe_sum     = pe_acc;

  always @(posedge clk) begin
    if (!reset_n) pe_acc <= '0;
    else if (pe_ce && !skip_cond)
      pe_acc <= pe_accumulate ? pe_acc + pe_dot(pe_weight, pe_activation, pe_mask,
                                                pe_precision_mode) : '0;
  end

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Issues a command, streams bw/ba/bm, returns the cycle res_valid is seen (-1 on timeout).
  task automatic run_job(input logic [2:0] prec, input int len, input int gap,
                         output int res_cyc);
    int cyc, idx;
    logic took;
    cmd_valid = 1'b1; cmd_precision = prec; cmd_len = LW'(len);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cyc = 1; idx = 0; res_cyc = -1;
    n_cmp++;
    if (pe_ce !== 1'b1 || pe_accumulate !== 1'b0 || pe_weight !== ONES || pe_mask !== ONES ||
        cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_cycle: ce=%b acc=%b w=%h m=%h cmd_ready=%b, need ce=1 acc=0 w=m=ones cmd_ready=0",
               pe_ce, pe_accumulate, pe_weight, pe_mask, cmd_ready);
    end
    while (res_cyc < 0 && cyc < 100) begin
      if (res_valid) res_cyc = cyc;
      else begin
        if (idx < len && cyc >= 2 + gap) begin
          op_valid = 1'b1; op_weight = bw[idx]; op_activation = ba[idx]; op_mask = bm[idx];
        end else op_valid = 1'b0;
        took = op_valid && op_ready;
        @(posedge clk); #1;
        cyc++;
        if (took) idx++;
      end
    end
    op_valid = 1'b0;
  endtask

  task automatic finish_job();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    n_cmp++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL after_handshake: cmd_ready=%b res_valid=%b, need 1/0", cmd_ready, res_valid);
    end
  endtask

  task automatic check_result(input string name, input int rc, input int exp_rc,
                              input logic [AW-1:0] exp_sum, input logic exp_err,
                              input logic [2:0] exp_mode);
    n_cmp++;
    if (rc !== exp_rc) begin
      n_fail++; $display("FAIL %s_latency: res_valid cycle %0d, need %0d", name, rc, exp_rc);
    end
    n_cmp++;
    if (res_sum !== exp_sum) begin
      n_fail++; $display("FAIL %s_sum: got %0d, need %0d", name, res_sum, exp_sum);
    end
    n_cmp++;
    if (res_prec_err !== exp_err || pe_precision_mode !== exp_mode) begin
      n_fail++;
      $display("FAIL %s_prec: err=%b mode=%b, need err=%b mode=%b", name, res_prec_err,
               pe_precision_mode, exp_err, exp_mode);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, res_valid, op_ready, pe_ce, pe_accumulate, res_prec_err} !== 6'b0 ||
        pe_precision_mode !== 3'b000 || res_sum !== '0 ||
        (pe_weight | pe_activation | pe_mask) !== '0 || stat_beats !== 0 || stat_skipped !== 0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b rv=%b opr=%b ce=%b mode=%b sum=%0d stats=%0d/%0d, need all 0",
               busy, res_valid, op_ready, pe_ce, pe_precision_mode, res_sum, stat_beats, stat_skipped);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: cmd_ready=%b busy=%b, need 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_basic_1b();
    int rc;
    for (int i = 0; i < 2; i++) begin bw[i] = ONES; ba[i] = ONES; bm[i] = ONES; end
    run_job(3'b000, 2, 0, rc);
    check_result("basic_1b", rc, 6, 20'd128, 1'b0, 3'b000);
    finish_job();
  endtask

  task automatic test_gap_8b();
    int rc;
    bw[0] = 64'h0101_0101_0101_0101; ba[0] = 64'h0101_0101_0101_0101; bm[0] = ONES;
    run_job(3'b011, 1, 3, rc);
    check_result("gap_8b", rc, 8, 20'd8, 1'b0, 3'b011);
    finish_job();
  endtask

  task automatic test_len_zero();
    int rc;
    bw[0] = 64'h14; ba[0] = 64'h19; bm[0] = ONES;
    run_job(3'b011, 1, 0, rc);
    check_result("prior_500", rc, 5, 20'd500, 1'b0, 3'b011);
    finish_job();
    run_job(3'b011, 0, 0, rc);
    check_result("len_zero", rc, 3, 20'd0, 1'b0, 3'b011);
    finish_job();
  endtask

  task automatic test_prec_err();
    int rc;
    bw[0] = ONES; ba[0] = ONES; bm[0] = ONES;
    run_job(3'b101, 1, 0, rc);
    check_result("prec_err", rc, 5, 20'd64, 1'b1, 3'b000);
    finish_job();
  endtask

  task automatic test_hold_result();
    int rc;
    bw[0] = ONES; ba[0] = ONES; bm[0] = ONES;
    run_job(3'b010, 1, 0, rc);
    check_result("hold_4b", rc, 5, 20'd3600, 1'b0, 3'b010);
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (res_valid !== 1'b1 || cmd_ready !== 1'b0 || res_sum !== 20'd3600) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: rv=%b cmd_ready=%b sum=%0d, need 1/0/3600", i, res_valid,
                 cmd_ready, res_sum);
      end
      @(posedge clk); #1;
    end
    finish_job();
  endtask

  task automatic test_stats_and_abort();
    int rc;
    logic [31:0] exp_b, exp_s;
`ifdef PE_SEQ_STATS_EN
    exp_b = 32'd4; exp_s = 32'd1;
`else
    exp_b = 32'd0; exp_s = 32'd0;
`endif
    do_reset();
    for (int i = 0; i < 4; i++) begin bw[i] = ONES; ba[i] = ONES; bm[i] = ONES; end
    bw[1] = '0;
    run_job(3'b000, 4, 0, rc);
    check_result("stats_job", rc, 8, 20'd192, 1'b0, 3'b000);
    n_cmp++;
    if (stat_beats !== exp_b || stat_skipped !== exp_s) begin
      n_fail++;
      $display("FAIL stats_counts: beats=%0d skipped=%0d, need %0d/%0d", stat_beats, stat_skipped,
               exp_b, exp_s);
    end
    finish_job();
    // Start a 4-beat job and abort it after two beats.
    cmd_valid = 1'b1; cmd_precision = 3'b011; cmd_len = 16'd4;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    op_valid = 1'b1; op_weight = ONES; op_activation = ONES; op_mask = ONES;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b1 || op_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_stream: busy=%b op_ready=%b, need 1/1", busy, op_ready);
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    op_valid = 1'b0;
    n_cmp++;
    if ({busy, res_valid, op_ready, pe_ce, pe_accumulate, res_prec_err} !== 6'b0 ||
        pe_precision_mode !== 3'b000 || res_sum !== '0 || pe_weight !== '0 ||
        stat_beats !== 0 || stat_skipped !== 0) begin
      n_fail++;
      $display("FAIL abort_outputs: busy=%b rv=%b opr=%b ce=%b mode=%b sum=%0d stats=%0d/%0d, need all 0",
               busy, res_valid, op_ready, pe_ce, pe_precision_mode, res_sum, stat_beats, stat_skipped);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_release: cmd_ready=%b busy=%b, need 1/0", cmd_ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_1b();
    test_gap_8b();
    test_len_zero();
    test_prec_err();
    test_hold_result();
    test_stats_and_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
